rice_core_if_stage: RTL and testbench

Instruction-fetch stage. It owns the PC, issues in-order word fetches on the instruction bus, and buffers returned instructions in a small credit-controlled queue. It presents one instruction per cycle as pipeline_if.if_result to the decode stage directly downstream. It honours pipeline stall, flush (redirect to pipeline_if.flush_pc) and the core enable, and discards responses belonging to pre-flush requests.

---
 rtl/rice_core_pkg.sv | 22 ++
 rtl/rice_core_if_stage_if.sv | 25 ++
 rtl/rice_core_if_fifo.sv | 73 +++++++
 rtl/rice_core_if_stage.sv | 138 +++++++++++++
 tb/tb_rice_core_if_stage.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rice_core_pkg.sv
// Shared types for the rice_core pipeline.
// Fetch-stage result bundle and PC/instruction word types.
package rice_core_pkg;

    localparam int RICE_CORE_XLEN = 32;
    localparam int RICE_CORE_INST_BYTES = 4;

    typedef logic [RICE_CORE_XLEN-1:0] rice_core_pc;
    typedef logic [31:0] rice_core_inst;

    typedef struct packed {
        logic          valid;
        rice_core_pc   pc;
        rice_core_inst inst;
    } rice_core_if_result;

    typedef struct packed {
        rice_core_pc   pc;
        rice_core_inst inst;
    } rice_core_fetch_entry;

endpackage

// File: rtl/rice_core_if_stage_if.sv
// Fetch/decode pipeline handshake.
// Fetch drives the result; decode drives stall and redirect.
interface rice_core_pipeline_if;
    import rice_core_pkg::*;

    rice_core_if_result if_result;
    logic               stall;
    logic               flush;
    rice_core_pc        flush_pc;

    modport if_stage (
        output if_result,
        input  stall,
        input  flush,
        input  flush_pc
    );

    modport id_stage (
        input  if_result,
        output stall,
        output flush,
        output flush_pc
    );

endinterface

// File: rtl/rice_core_if_fifo.sv
// Small instruction queue of {pc, inst} entries.
// Clear wins over push and pop.
module rice_core_if_fifo
    import rice_core_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 clear,
    input  rice_core_fetch_entry wdata,
    output logic [CW-1:0]        count,
    output logic                 empty,
    output logic                 full,
    output rice_core_fetch_entry head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PONE = PW'(1);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] FULL_N = CW'(DEPTH);

    rice_core_fetch_entry mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;

    assign empty  = (count == '0);
    assign full   = (count == FULL_N);
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    function automatic logic [PW-1:0] nxt(
        input logic [PW-1:0] p
    );
        return (p == LAST) ? '0 : p + PONE;
    endfunction

    always_ff @(posedge i_clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= nxt(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            unique case ({push, do_pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rice_core_if_stage.sv
// Instruction fetch: owns the PC, issues in-order fetches and
// buffers responses in a credit-limited queue for decode.
module rice_core_if_stage
    import rice_core_pkg::*;
#(
    parameter int               XLEN       = 32,
    parameter logic [XLEN-1:0]  INIT_PC    = '0,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    rice_core_pipeline_if.if_stage pipeline_if,
    output logic                   o_inst_request_valid,
    input  logic                   i_inst_request_ready,
    output logic [XLEN-1:0]        o_inst_request_address,
    input  logic                   i_inst_response_valid,
    input  rice_core_inst          i_inst_response_data
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [XLEN-1:0] STEP = XLEN'(RICE_CORE_INST_BYTES);
    localparam logic [XLEN-1:0] LOW2 = XLEN'(3);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] response_pc;
    logic [XLEN-1:0] flush_target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   q_count;
    logic            q_empty;
    logic            q_full;
    logic            flush;
    logic            stall;
    logic            accept;
    logic            resp;
    logic            push;
    logic            pop;

    rice_core_fetch_entry q_wdata;
    rice_core_fetch_entry q_head;
    rice_core_if_result   result;
    rice_core_if_result   result_next;

    assign flush        = pipeline_if.flush;
    assign stall        = pipeline_if.stall;
    assign flush_target = pipeline_if.flush_pc & ~LOW2;

    // Credits cover both in-flight requests and queued words.
    assign o_inst_request_valid = i_rst_n && i_enable && !flush
        && (({1'b0, outstanding} + {1'b0, q_count}) < CREDITS);
    assign o_inst_request_address = pc;

    assign accept = o_inst_request_valid && i_inst_request_ready;
    assign resp   = i_inst_response_valid;
    assign push   = resp && (discard == '0) && !flush;
    assign pop    = !flush && i_enable && !stall && !q_empty;

    assign q_wdata = '{pc: response_pc, inst: i_inst_response_data};

    rice_core_if_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (push),
        .pop     (pop),
        .clear   (flush),
        .wdata   (q_wdata),
        .count   (q_count),
        .empty   (q_empty),
        .full    (q_full),
        .head    (q_head)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc          <= INIT_PC;
            response_pc <= INIT_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            unique case ({accept, resp})
                2'b10:   outstanding <= outstanding + ONE;
                2'b01:   outstanding <= outstanding - ONE;
                default: outstanding <= outstanding;
            endcase
            if (flush) begin
                pc          <= flush_target;
                response_pc <= flush_target;
                // Everything still in flight belongs to the old path.
                discard     <= resp ? outstanding - ONE : outstanding;
            end else begin
                if (accept) begin
                    pc <= pc + STEP;
                end
                if (push) begin
                    response_pc <= response_pc + STEP;
                end
                if (resp && (discard != '0)) begin
                    discard <= discard - ONE;
                end
            end
        end
    end

    always_comb begin
        result_next = result;
        if (flush || !i_enable) begin
            result_next.valid = 1'b0;
        end else if (!stall) begin
            result_next.valid = pop;
            if (pop) begin
                result_next.pc   = q_head.pc;
                result_next.inst = q_head.inst;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result <= '0;
        end else begin
            result <= result_next;
        end
    end

    assign pipeline_if.if_result = result;

    credit_a: assert property (
        @(posedge i_clk) disable iff (!i_rst_n)
        !(push && q_full)
    );

endmodule

// File: tb/tb_rice_core_if_stage.sv
// Bench for rice_core_if_stage: in-order bus responder plus a
// transaction-level model of the expected fetch stream.
module tb_rice_core_if_stage;
    import rice_core_pkg::*;

    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        req_ready;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;

    rice_core_pipeline_if pif ();

    rice_core_if_stage #(
        .XLEN       (32),
        .INIT_PC    (32'h0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_enable               (enable),
        .pipeline_if            (pif),
        .o_inst_request_valid   (req_valid),
        .i_inst_request_ready   (req_ready),
        .o_inst_request_address (req_addr),
        .i_inst_response_valid  (resp_valid),
        .i_inst_response_data   (resp_data)
    );

    always #5 clk = ~clk;

    bus_t        bq[$];
    logic [31:0] mq[$];
    int          cycle;
    int          lat;
    int          last_due;
    int          discard_m;
    logic [31:0] fetch_pc;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_inst;
    logic        last_req;
    logic        last_acc;
    logic [31:0] last_addr;
    int          vec;
    int          miscmp;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        vec++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %08h expected %08h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick(
        input logic        en,
        input logic        st,
        input logic        fl,
        input logic [31:0] fpc
    );
        logic        exp_req;
        logic        acc;
        logic        rsp;
        logic [31:0] raddr;
        bus_t        b;
        int          d;
        raddr = '0;
        enable       = en;
        pif.stall    = st;
        pif.flush    = fl;
        pif.flush_pc = fpc;
        rsp = (bq.size() > 0) && (bq[0].due <= cycle);
        resp_valid = rsp;
        resp_data  = rsp ? mem(bq[0].addr) : $urandom;
        #1;
        exp_req = en && !fl && (bq.size() + mq.size() < DEPTH);
        chk("req_valid", 32'(req_valid), 32'(exp_req));
        if (exp_req) chk("req_addr", req_addr, fetch_pc);
        acc       = req_valid && req_ready;
        last_req  = req_valid;
        last_acc  = acc;
        last_addr = req_addr;
        @(posedge clk);
        #1;
        if (rsp) begin
            b = bq.pop_front();
            raddr = b.addr;
        end
        if (fl) begin
            discard_m = bq.size();
            mq.delete();
            ex_valid = 1'b0;
            fetch_pc = fpc & ~32'd3;
        end else begin
            if (!en) begin
                ex_valid = 1'b0;
            end else if (!st) begin
                if (mq.size() > 0) begin
                    ex_valid = 1'b1;
                    ex_pc    = mq.pop_front();
                    ex_inst  = mem(ex_pc);
                end else begin
                    ex_valid = 1'b0;
                end
            end
            if (rsp) begin
                if (discard_m > 0) discard_m--;
                else mq.push_back(raddr);
            end
            if (acc) begin
                d = (cycle + lat > last_due) ? cycle + lat : last_due;
                last_due = d;
                bq.push_back('{addr: fetch_pc, due: d});
                fetch_pc = fetch_pc + 32'd4;
            end
        end
        chk("if_valid", 32'(pif.if_result.valid), 32'(ex_valid));
        chk("if_pc", pif.if_result.pc, ex_pc);
        chk("if_inst", pif.if_result.inst, ex_inst);
        @(negedge clk);
        cycle++;
    endtask

    task automatic first_valid(output logic [31:0] p);
        int n;
        n = 0;
        p = 32'hDEAD_BEEF;
        while (n < 30) begin
            tick(1'b1, 1'b0, 1'b0, '0);
            n++;
            if (pif.if_result.valid) begin
                p = pif.if_result.pc;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] p;
        logic [31:0] snap_pc;
        logic [31:0] fpc;
        logic        en;
        logic        st;
        logic        fl;
        int          n;
        vec = 0; miscmp = 0; cycle = 0; lat = 1; last_due = 0;
        discard_m = 0; fetch_pc = '0;
        ex_valid = 1'b0; ex_pc = '0; ex_inst = '0;
        last_req = 1'b0; last_acc = 1'b0; last_addr = '0;
        rst_n = 1'b0; enable = 1'b1; req_ready = 1'b1;
        resp_valid = 1'b0; resp_data = '0;
        pif.stall = 1'b0; pif.flush = 1'b0; pif.flush_pc = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(pif.if_result.valid), 32'd0);
        chk("rst_pc", pif.if_result.pc, 32'd0);
        chk("rst_inst", pif.if_result.inst, 32'd0);
        chk("rst_req", 32'(req_valid), 32'd0);
        chk("rst_addr", req_addr, 32'd0);
        rst_n = 1'b1;

        // Sequential fetch from reset.
        repeat (12) tick(1'b1, 1'b0, 1'b0, '0);

        // Stall: result frozen, credits run out.
        snap_pc = pif.if_result.pc;
        repeat (5) tick(1'b1, 1'b1, 1'b0, '0);
        chk("stall_req_drop", 32'(last_req), 32'd0);
        chk("stall_hold_pc", pif.if_result.pc, snap_pc);
        repeat (6) tick(1'b1, 1'b0, 1'b0, '0);

        // Redirect with two requests in flight.
        lat = 4; n = 0;
        while (bq.size() != 2 && n < 20) begin
            tick(1'b1, 1'b0, 1'b0, '0);
            n++;
        end
        chk("two_outstanding", 32'(bq.size()), 32'd2);
        tick(1'b1, 1'b0, 1'b1, 32'h103);
        first_valid(p);
        chk("flush_first_pc", p, 32'h100);

        // Redirect coinciding with a response, under stall.
        lat = 1;
        repeat (4) tick(1'b1, 1'b0, 1'b0, '0);
        n = 0;
        while (!(bq.size() > 0 && bq[0].due <= cycle) && n < 20) begin
            tick(1'b1, 1'b0, 1'b0, '0);
            n++;
        end
        tick(1'b1, 1'b1, 1'b1, 32'h200);
        chk("flush_resp_valid", 32'(pif.if_result.valid), 32'd0);
        first_valid(p);
        chk("flush2_first_pc", p, 32'h200);

        // PC wrap.
        tick(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        first_valid(p);
        chk("wrap_pc0", p, 32'hFFFF_FFFC);
        first_valid(p);
        chk("wrap_pc1", p, 32'h0);

        // Disable with one request outstanding.
        lat = 3;
        tick(1'b1, 1'b0, 1'b1, 32'h300);
        req_ready = 1'b0; n = 0;
        while (bq.size() != 0 && n < 20) begin
            tick(1'b1, 1'b0, 1'b0, '0);
            n++;
        end
        req_ready = 1'b1;
        tick(1'b1, 1'b0, 1'b0, '0);
        chk("en_accept", 32'(last_acc), 32'd1);
        chk("en_accept_addr", last_addr, 32'h300);
        repeat (3) tick(1'b0, 1'b0, 1'b0, '0);
        chk("en_no_req", 32'(last_req), 32'd0);
        first_valid(p);
        chk("en_first_pc", p, 32'h300);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            lat       = $urandom_range(1, 3);
            req_ready = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 9) != 0);
            st        = ($urandom_range(0, 4) == 0);
            fl        = ($urandom_range(0, 19) == 0);
            fpc       = ($urandom_range(0, 3) == 0)
                      ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                      : $urandom;
            tick(en, st, fl, fpc);
        end

        // Drain: the stream must keep flowing.
        req_ready = 1'b1; lat = 1; n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0, 1'b0, '0);
            if (pif.if_result.valid) n++;
        end
        chk("drain_live", 32'(n >= 5), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec, miscmp);
        $finish;
    end

endmodule
